// File: rtl/kon_slot_scheduler.sv
// Key-on/key-off slot scheduler: rotates a channel pointer through NCH time slots and
// turns latched CPU start/stop requests and end-of-sample hits into datapath strobes.
module kon_slot_scheduler #(
  parameter int NCH      = 8,
  parameter int SLOT_CYC = 4,
  parameter int CHW      = 3
) (
  input  logic           clk_i,
  input  logic           res_i,
  input  logic [7:0]     db_in_i,
  input  logic           konwr_i,
  input  logic           koffwr_i,
  input  logic [NCH-1:0] loop_en_i,
  input  logic           end_hit_i,
  output logic [CHW-1:0] slot_ch_o,
  output logic           slot_start_o,
  output logic           ch_start_o,
  output logic           ch_stop_o,
  output logic           ch_reload_o,
  output logic [NCH-1:0] ch_active_o,
  output logic [NCH-1:0] kon_pend_o,
  output logic [NCH-1:0] koff_pend_o
);

  localparam int PW = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
  localparam logic [PW-1:0]  PH_LAST = PW'(SLOT_CYC - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

  // ST_IDLE is the single cycle after reset before phase 0 of channel 0 begins.
  typedef enum logic {ST_IDLE, ST_RUN} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  phase_q, phase_d;
  logic [CHW-1:0] slot_ch_q, slot_ch_d;
  logic           slot_start_q, slot_start_d;
  logic [NCH-1:0] kon_q, kon_d;
  logic [NCH-1:0] koff_q, koff_d;
  logic [NCH-1:0] active_q, active_d;
  logic           start_q, start_d;
  logic           stop_q, stop_d;
  logic           reload_q, reload_d;

  logic [NCH-1:0] ch_bit;
  logic [NCH-1:0] wr_bits;
  logic           svc_slot, end_slot;
  logic           svc_koff, svc_kon;
  logic           end_valid, end_loop;

  always_comb begin
    ch_bit    = NCH'(1) << slot_ch_q;
    wr_bits   = db_in_i[NCH-1:0];
    svc_slot  = (state_q == ST_RUN) && (phase_q == '0);
    end_slot  = (state_q == ST_RUN) && (phase_q == PH_LAST);
    svc_koff  = svc_slot && (|(koff_q & ch_bit));
    svc_kon   = svc_slot && !svc_koff && (|(kon_q & ch_bit));
    end_valid = end_slot && end_hit_i && (|(active_q & ch_bit));
    end_loop  = |(loop_en_i & ch_bit);
  end

  // Slot sequencer: phase counter with channel advance on wrap.
  always_comb begin
    state_d   = ST_RUN;
    phase_d   = phase_q;
    slot_ch_d = slot_ch_q;
    if (state_q == ST_IDLE) begin
      phase_d   = '0;
      slot_ch_d = '0;
    end else if (phase_q == PH_LAST) begin
      phase_d   = '0;
      slot_ch_d = (slot_ch_q == CH_LAST) ? '0 : slot_ch_q + CHW'(1);
    end else begin
      phase_d = phase_q + PW'(1);
    end
    slot_start_d = (phase_d == '0);
  end

  // Service clears only the serviced bit; writes are applied afterwards so none is lost.
  always_comb begin
    kon_d    = kon_q;
    koff_d   = koff_q;
    active_d = active_q;
    if (svc_koff) begin
      koff_d   = koff_d & ~ch_bit;
      active_d = active_d & ~ch_bit;
    end
    if (svc_kon) begin
      kon_d    = kon_d & ~ch_bit;
      active_d = active_d | ch_bit;
    end
    if (end_valid && !end_loop) begin
      active_d = active_d & ~ch_bit;
    end
    // A key-off write takes precedence over a simultaneous key-on write.
    if (koffwr_i) begin
      koff_d = koff_d | wr_bits;
      kon_d  = kon_d & ~wr_bits;
    end else if (konwr_i) begin
      kon_d  = kon_d | wr_bits;
      koff_d = koff_d & ~wr_bits;
    end
    start_d  = svc_kon;
    stop_d   = svc_koff || (end_valid && !end_loop);
    reload_d = end_valid && end_loop;
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      slot_ch_q    <= '0;
      slot_start_q <= 1'b0;
      kon_q        <= '0;
      koff_q       <= '0;
      active_q     <= '0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      reload_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      slot_ch_q    <= slot_ch_d;
      slot_start_q <= slot_start_d;
      kon_q        <= kon_d;
      koff_q       <= koff_d;
      active_q     <= active_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      reload_q     <= reload_d;
    end
  end

  assign slot_ch_o    = slot_ch_q;
  assign slot_start_o = slot_start_q;
  assign ch_start_o   = start_q;
  assign ch_stop_o    = stop_q;
  assign ch_reload_o  = reload_q;
  assign ch_active_o  = active_q;
  assign kon_pend_o   = kon_q;
  assign koff_pend_o  = koff_q;

endmodule

// File: tb/tb_kon_slot_scheduler.sv
// Directed bench for kon_slot_scheduler: expected strobe events go into a queue that a
// negedge monitor drains, alongside per-cycle slot timing and flag checks.
module tb_kon_slot_scheduler;

  localparam int NCH = 8;
  localparam int SC  = 4;
  localparam int ROT = NCH * SC;

  localparam logic [2:0] T_START  = 3'b001;
  localparam logic [2:0] T_STOP   = 3'b010;
  localparam logic [2:0] T_RELOAD = 3'b100;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [7:0]     db_in = '0;
  logic           konwr = 1'b0;
  logic           koffwr = 1'b0;
  logic [NCH-1:0] loop_en = '0;
  logic           end_hit = 1'b0;
  logic [2:0]     slot_ch;
  logic           slot_start;
  logic           ch_start, ch_stop, ch_reload;
  logic [NCH-1:0] ch_active, kon_pend, koff_pend;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // {cycle[15:0], {reload, stop, start}, slot_ch}
  logic [21:0] exp_q[$];

  kon_slot_scheduler #(.NCH(NCH), .SLOT_CYC(SC), .CHW(3)) dut (
    .clk_i(clk), .res_i(rst), .db_in_i(db_in), .konwr_i(konwr), .koffwr_i(koffwr),
    .loop_en_i(loop_en), .end_hit_i(end_hit), .slot_ch_o(slot_ch),
    .slot_start_o(slot_start), .ch_start_o(ch_start), .ch_stop_o(ch_stop),
    .ch_reload_o(ch_reload), .ch_active_o(ch_active), .kon_pend_o(kon_pend),
    .koff_pend_o(koff_pend)
  );

  // clock / reset-relative cycle count (cycle 1 = phase 0 of channel 0)
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int ph(input int n);
    return (n - 1) % SC;
  endfunction

  function automatic int sl(input int n);
    return ((n - 1) / SC) % NCH;
  endfunction

  // cycle in which the start/stop strobe appears for a request written in cycle n
  function automatic int svc(input int n, input int c);
    int m;
    m = n + 1;
    while (((m - 1) % ROT) != SC * c) m++;
    return m + 1;
  endfunction

  task automatic push(input int at, input logic [2:0] typ, input int ch);
    logic [15:0] c16;
    logic [2:0]  ch3;
    c16 = 16'(at);
    ch3 = 3'(ch);
    exp_q.push_back({c16, typ, ch3});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int s, input int p);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(ph(cyc) == p && sl(cyc) == s) && k < 80);
    if (k >= 80) begin
      n_cmp++;
      n_err++;
      $display("FAIL goto: slot %0d phase %0d not reached within 80 cycles", s, p);
    end
  endtask

  task automatic write(input logic kon, input logic koff, input logic [7:0] d);
    konwr  = kon;
    koffwr = koff;
    db_in  = d;
    tick();
    konwr  = 1'b0;
    koffwr = 1'b0;
    db_in  = '0;
  endtask

  task automatic chk_flags(input string name, input logic [7:0] act_e, input logic [7:0] kon_e,
                           input logic [7:0] koff_e);
    chk({name, ".active"}, 32'(ch_active), 32'(act_e));
    chk({name, ".kon_pend"}, 32'(kon_pend), 32'(kon_e));
    chk({name, ".koff_pend"}, 32'(koff_pend), 32'(koff_e));
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [2:0]  exp_ch;
    logic        exp_ss;
    logic [2:0]  strb;
    logic [21:0] obs, e;
    exp_ch = (cyc == 0) ? 3'd0 : 3'(sl(cyc));
    exp_ss = (cyc != 0) && (ph(cyc) == 0);
    chk("slot_ch", 32'(slot_ch), 32'(exp_ch));
    chk("slot_start", 32'(slot_start), 32'(exp_ss));
    strb = {ch_reload, ch_stop, ch_start};
    if (strb != 3'b000) begin
      obs = {cyc[15:0], strb, slot_ch};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL strobe_unexpected: got strobes %b ch %0d at cycle %0d, expected none",
                 strb, slot_ch, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_event", 32'(obs), 32'(e));
      end
    end
  end

  initial begin
    int n, m;

    // reset and free-run
    @(negedge clk);
    chk_flags("reset", 8'h00, 8'h00, 8'h00);
    chk("reset.strobes", 32'({ch_reload, ch_stop, ch_start}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) tick();
    @(negedge clk);
    chk_flags("freerun", 8'h00, 8'h00, 8'h00);

    // key-on of channels 0 and 2 written during slot 1
    goto(1, 0);
    n = cyc;
    write(1'b1, 1'b0, 8'h05);
    push(svc(n, 2), T_START, 2);
    push(svc(n, 0), T_START, 0);
    @(negedge clk);
    chk("kon05.kon_pend", 32'(kon_pend), 32'h05);
    goto(0, 2);
    @(negedge clk);
    chk_flags("kon05.done", 8'h05, 8'h00, 8'h00);

    // channel 3 end without loop; END_HIT also held during phase 2, which must be ignored
    goto(4, 0);
    n = cyc;
    write(1'b1, 1'b0, 8'h08);
    push(svc(n, 3), T_START, 3);
    goto(3, 2);
    end_hit = 1'b1;
    tick();
    push(cyc + 1, T_STOP, 4);
    tick();
    end_hit = 1'b0;
    @(negedge clk);
    chk("end_stop.active", 32'(ch_active), 32'h05);

    // end on an inactive channel produces nothing
    goto(5, 3);
    end_hit = 1'b1;
    tick();
    end_hit = 1'b0;

    // channel 3 end with loop enabled reloads and stays active
    loop_en = 8'h08;
    n = cyc;
    write(1'b1, 1'b0, 8'h08);
    push(svc(n, 3), T_START, 3);
    goto(3, 3);
    end_hit = 1'b1;
    push(cyc + 1, T_RELOAD, 4);
    tick();
    end_hit = 1'b0;
    @(negedge clk);
    chk("end_reload.active", 32'(ch_active), 32'h0D);

    // write ordering: KON then KOFF on ch4; simultaneous KON+KOFF on ch2/ch6
    goto(0, 0);
    n = cyc;
    write(1'b1, 1'b0, 8'h10);
    write(1'b0, 1'b1, 8'h10);
    write(1'b1, 1'b1, 8'h44);
    push(svc(n + 2, 2), T_STOP, 2);
    push(svc(n + 1, 4), T_STOP, 4);
    push(svc(n + 2, 6), T_STOP, 6);
    @(negedge clk);
    chk("order.kon_pend", 32'(kon_pend), 32'h00);
    chk("order.koff_pend", 32'(koff_pend), 32'h54);
    goto(7, 0);
    @(negedge clk);
    chk_flags("order.done", 8'h09, 8'h00, 8'h00);

    // new KON for ch0 in the very cycle an older ch0 request is serviced
    n = cyc;
    write(1'b1, 1'b0, 8'h01);
    push(svc(n, 0), T_START, 0);
    goto(0, 0);
    m = cyc;
    write(1'b1, 1'b0, 8'h01);
    push(svc(m, 0), T_START, 0);
    @(negedge clk);
    chk("collide.kon_pend", 32'(kon_pend), 32'h01);
    goto(1, 0);
    goto(1, 0);
    @(negedge clk);
    chk_flags("collide.done", 8'h09, 8'h00, 8'h00);

    // reset at phase 2 with every channel pending
    goto(7, 0);
    write(1'b1, 1'b0, 8'hFF);
    tick();
    @(negedge clk);
    chk("midreset.pre_kon", 32'(kon_pend), 32'hFF);
    rst = 1'b1;
    #1;
    chk_flags("midreset", 8'h00, 8'h00, 8'h00);
    chk("midreset.strobes", 32'({ch_reload, ch_stop, ch_start}), 32'd0);
    chk("midreset.slot_ch", 32'(slot_ch), 32'd0);
    chk("midreset.slot_start", 32'(slot_start), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (ROT + 8) tick();
    @(negedge clk);
    chk_flags("after_reset", 8'h00, 8'h00, 8'h00);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // final report
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
